// File: rtl/uart_pkg.sv
// Shared UART definitions for the receive and transmit sides of the
// parity-protected serial link.
//   rx_state_t      : receiver FSM state encoding
//   UART_IDLE_LEVEL : line level when no frame is in flight
//   parity_of()     : XOR-reduce a vector and fold in the odd/even selector
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_t;

  localparam logic UART_IDLE_LEVEL = 1'b1;

  // Widest vector parity_of accepts; callers zero-extend narrower inputs,
  // which leaves the XOR unchanged.
  localparam int PAR_MAX_W = 16;

  // Returns 1 when the XOR of vec does not match the selected sense
  // (even: expect 0, odd: expect 1).
  function automatic logic parity_of(input logic [PAR_MAX_W-1:0] vec,
                                     input logic                 odd);
    return (^vec) ^ odd;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input.
//   clk : destination clock
//   rst : synchronous active-high reset, loads both flops with RST_VAL
//   d   : asynchronous input
//   q   : synchronized output, 2 cycles behind d
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_parity_rx.sv
// UART receiver: start bit, DATA_BITS data bits (LSB first), one parity bit,
// one stop bit. Each frame ends with a one-cycle valid pulse carrying the
// word and the parity / framing error flags.
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   rx         : asynchronous serial input, idles high
//   data       : last received word, held until the next valid
//   valid      : one-cycle pulse per completed frame (errored frames too)
//   parity_err : parity mismatch, qualified by valid, held until next valid
//   frame_err  : stop bit sampled low, qualified by valid, held likewise
//   busy       : high from start detection until the FSM is back in IDLE
module uart_parity_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int             CW   = $clog2(CLKS_PER_BIT);
  localparam int             IW   = $clog2(DATA_BITS);
  localparam logic [CW-1:0]  HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]  FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0]  LAST = IW'(DATA_BITS - 1);
  localparam logic           ODD  = (PARITY_ODD != 0);

  logic                 rx_s;
  logic                 rx_d;
  rx_state_t            state;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 acc;
  logic                 perr;

  sync_2ff #(.RST_VAL(UART_IDLE_LEVEL)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  wire expired = (cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      acc        <= 1'b0;
      perr       <= 1'b0;
      // Cleared (not idle level) so a line held low through reset cannot
      // look like a falling edge: rx_s must be seen high first.
      rx_d       <= 1'b0;
      data       <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      rx_d  <= rx_s;
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_d && !rx_s) begin
            cnt   <= HALF;
            state <= START;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (!expired) begin
            cnt <= cnt - 1'b1;
          end else if (rx_s) begin
            // Line went back high by mid start bit: glitch, drop it.
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            acc     <= 1'b0;
            bit_idx <= '0;
            cnt     <= FULL;
            state   <= DATA;
          end
        end
        DATA: begin
          if (!expired) begin
            cnt <= cnt - 1'b1;
          end else begin
            shreg <= {rx_s, shreg[DATA_BITS-1:1]};
            acc   <= acc ^ rx_s;
            cnt   <= FULL;
            if (bit_idx == LAST) state <= PARITY;
            else                 bit_idx <= bit_idx + 1'b1;
          end
        end
        PARITY: begin
          if (!expired) begin
            cnt <= cnt - 1'b1;
          end else begin
            perr  <= parity_of(PAR_MAX_W'({acc, rx_s}), ODD);
            cnt   <= FULL;
            state <= STOP;
          end
        end
        STOP: begin
          if (!expired) begin
            cnt <= cnt - 1'b1;
          end else begin
            data       <= shreg;
            valid      <= 1'b1;
            parity_err <= perr;
            frame_err  <= ~rx_s;
            if (rx_s) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= BREAK;
            end
          end
        end
        BREAK: begin
          // Line held low past the stop bit; ignore it until it recovers.
          if (rx_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_parity_rx.sv
// Directed bench for uart_parity_rx. Two instances share clock and reset:
// dut0 uses even parity, dut1 odd parity. Each frame sent records its
// expected word, flags and arrival cycle; a single compare process checks
// both instances every cycle against those records.
module tb_uart_parity_rx;

  localparam int CPB = 16;
  localparam int LAT = 10 * CPB + CPB / 2 + 3;  // 171 cycles to valid

  typedef struct {
    int         due;
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rst_q = 1'b1;
  logic       rx0 = 1'b1, rx1 = 1'b1;
  logic [7:0] data0, data1;
  logic       valid0, valid1, pe0, pe1, fe0, fe1, busy0, busy1;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_errs = 0;
  exp_t q0[$];
  exp_t q1[$];
  logic [7:0] last_d[2];
  logic       last_pe[2];
  logic       last_fe[2];

  uart_parity_rx #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY_ODD(0)) dut0 (
    .clk(clk), .rst(rst), .rx(rx0), .data(data0), .valid(valid0),
    .parity_err(pe0), .frame_err(fe0), .busy(busy0));

  uart_parity_rx #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY_ODD(1)) dut1 (
    .clk(clk), .rst(rst), .rx(rx1), .data(data1), .valid(valid1),
    .parity_err(pe1), .frame_err(fe1), .busy(busy1));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  task automatic check(input string name, input int ch,
                       input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s ch%0d cyc=%0d got=%0h expected=%0h", name, ch, cyc, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_rx(input int ch, input logic v);
    if (ch == 0) rx0 = v;
    else         rx1 = v;
  endtask

  // Drives one frame; abort_bit >= 0 pulses reset during that data bit and
  // abandons the frame with the line back at idle.
  task automatic send_frame(input int ch, input logic [7:0] d, input logic pb,
                            input logic sb, input int abort_bit);
    exp_t e;
    bit   odd;
    odd   = (ch == 1);
    e.due = cyc + LAT;
    e.d   = d;
    e.pe  = ((^d) ^ pb) != odd;
    e.fe  = ~sb;
    if (ch == 0) q0.push_back(e);
    else         q1.push_back(e);
    set_rx(ch, 1'b0);
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      set_rx(ch, d[i]);
      if (i == abort_bit) begin
        tick(CPB / 2);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        set_rx(ch, 1'b1);
        return;
      end
      tick(CPB);
    end
    set_rx(ch, pb);
    tick(CPB);
    set_rx(ch, sb);
    tick(CPB);
  endtask

  always @(negedge clk) begin
    for (int ch = 0; ch < 2; ch++) begin
      logic       v, pe, fe, bz, has;
      logic [7:0] d;
      exp_t       e;
      v  = (ch == 0) ? valid0 : valid1;
      pe = (ch == 0) ? pe0    : pe1;
      fe = (ch == 0) ? fe0    : fe1;
      bz = (ch == 0) ? busy0  : busy1;
      d  = (ch == 0) ? data0  : data1;
      e  = '{default: 0};
      if (ch == 0) begin has = (q0.size() != 0); if (has) e = q0[0]; end
      else         begin has = (q1.size() != 0); if (has) e = q1[0]; end
      if (rst_q) begin
        check("rst_valid", ch, 32'(v), 32'd0);
        check("rst_data",  ch, 32'(d), 32'd0);
        check("rst_perr",  ch, 32'(pe), 32'd0);
        check("rst_ferr",  ch, 32'(fe), 32'd0);
        check("rst_busy",  ch, 32'(bz), 32'd0);
        if (ch == 0) q0.delete(); else q1.delete();
        last_d[ch] = '0; last_pe[ch] = 1'b0; last_fe[ch] = 1'b0;
      end else if (v) begin
        check("valid_expected", ch, 32'(has), 32'd1);
        if (has) begin
          check("valid_cycle", ch, 32'(cyc), 32'(e.due));
          check("data",        ch, 32'(d),  32'(e.d));
          check("parity_err",  ch, 32'(pe), 32'(e.pe));
          check("frame_err",   ch, 32'(fe), 32'(e.fe));
          if (ch == 0) void'(q0.pop_front()); else void'(q1.pop_front());
          last_d[ch] = e.d; last_pe[ch] = e.pe; last_fe[ch] = e.fe;
        end
      end else begin
        if (has && cyc >= e.due) begin
          check("valid_missing", ch, 32'(v), 32'd1);
          if (ch == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        end
        check("hold_data", ch, 32'(d),  32'(last_d[ch]));
        check("hold_perr", ch, 32'(pe), 32'(last_pe[ch]));
        check("hold_ferr", ch, 32'(fe), 32'(last_fe[ch]));
      end
    end
  end

  initial begin
    rst = 1'b1; rx0 = 1'b1; rx1 = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(5);

    // Clean frame
    send_frame(0, 8'hA5, 1'b0, 1'b1, -1);
    tick(4);
    check("a5_data", 0, 32'(data0), 32'h0A5);
    check("a5_perr", 0, 32'(pe0), 32'd0);
    check("a5_ferr", 0, 32'(fe0), 32'd0);
    check("a5_busy", 0, 32'(busy0), 32'd0);

    // Wrong parity bit
    send_frame(0, 8'h07, 1'b0, 1'b1, -1);
    tick(4);
    check("07_data", 0, 32'(data0), 32'h07);
    check("07_perr", 0, 32'(pe0), 32'd1);
    check("07_ferr", 0, 32'(fe0), 32'd0);

    // Short low pulse: start detected, rejected mid start bit
    set_rx(0, 1'b0);
    tick(4);
    check("glitch_busy_hi", 0, 32'(busy0), 32'd1);
    set_rx(0, 1'b1);
    tick(12);
    check("glitch_busy_lo", 0, 32'(busy0), 32'd0);
    tick(10);

    // Framing error, line held low, then a clean frame
    send_frame(0, 8'h3C, 1'b0, 1'b0, -1);
    tick(100);
    check("break_busy", 0, 32'(busy0), 32'd1);
    check("3c_ferr", 0, 32'(fe0), 32'd1);
    check("3c_data", 0, 32'(data0), 32'h3C);
    set_rx(0, 1'b1);
    tick(20);
    check("break_exit_busy", 0, 32'(busy0), 32'd0);
    send_frame(0, 8'h81, 1'b0, 1'b1, -1);
    tick(4);
    check("81_data", 0, 32'(data0), 32'h81);
    check("81_perr", 0, 32'(pe0), 32'd0);
    check("81_ferr", 0, 32'(fe0), 32'd0);

    // Reset during data bit 3, then the frame again
    send_frame(0, 8'h55, 1'b0, 1'b1, 3);
    check("abort_data", 0, 32'(data0), 32'd0);
    check("abort_busy", 0, 32'(busy0), 32'd0);
    tick(20);
    send_frame(0, 8'h55, 1'b0, 1'b1, -1);
    tick(4);
    check("55_data", 0, 32'(data0), 32'h55);
    check("55_perr", 0, 32'(pe0), 32'd0);

    // Odd parity, back-to-back frames
    send_frame(1, 8'h00, 1'b1, 1'b1, -1);
    send_frame(1, 8'hFF, 1'b1, 1'b1, -1);
    tick(4);
    check("odd_ff_data", 1, 32'(data1), 32'hFF);
    check("odd_ff_perr", 1, 32'(pe1), 32'd0);
    check("odd_busy", 1, 32'(busy1), 32'd0);

    tick(10);
    check("queue_drained", 0, 32'(q0.size() + q1.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule

// File: doc/uart_parity_rx.md
# uart_parity_rx

Serial receiver for the parity-protected UART link: it samples an asynchronous `rx` line and reassembles frames of one start bit, DATA_BITS data bits (LSB first), one parity bit and one stop bit. A running XOR of the data bits checks the received parity. The block presents each completed word with a one-cycle `valid` pulse plus parity and framing error flags, and sits at the receive end of the link opposite the parity-generating transmitter.

## Interface
Parameters:
- `DATA_BITS`, 8: data bits per frame, range 5..9.
- `CLKS_PER_BIT`, 16: clock cycles per bit period, even, ≥ 4.
- `PARITY_ODD`, 0: 0 selects even parity (XOR of data and parity bits = 0); 1 selects odd parity (= 1).

Ports:
- `clk`  in  1: single clock; all logic is on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `rx`  in  1: asynchronous serial input; idles high.
- `data`  out  DATA_BITS: last received word; holds until the next `valid`.
- `valid`  out  1: one-cycle pulse per completed frame, including errored frames.
- `parity_err`  out  1: qualified by `valid`; parity mismatch.
- `frame_err`  out  1: qualified by `valid`; stop bit sampled low.
- `busy`  out  1: high from start-bit detection until return to IDLE.

## Operation
- `rx` passes through a 2-flop synchronizer. `rx_s` is the synchronized value.
- States: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE: a high-to-low transition of `rx_s` loads the bit counter with CLKS_PER_BIT/2−1 and enters START.
- START: at counter expiry (mid start bit), sample `rx_s`.
  - If it is high, treat the start as a glitch and return to IDLE with no `valid`.
  - If it is low, clear the parity accumulator, reload the counter with CLKS_PER_BIT−1 and go to DATA.
- DATA: at each expiry, shift `rx_s` into bit index 0..DATA_BITS−1 (LSB first) and XOR it into the accumulator. After the last bit, go to PARITY.
- PARITY: at expiry, `parity_err` = accumulator ^ `rx_s` ^ PARITY_ODD. Go to STOP.
- STOP: at expiry, register the shift register into `data`, pulse `valid`, and set `frame_err` = ~`rx_s`.
  - If the stop bit was high, go to IDLE.
  - If it was low, go to BREAK.
- BREAK: wait for `rx_s` high, then go to IDLE. No new start is detected while in BREAK.
- Error flags are registered with `valid` and are held until the next `valid`. Only `valid` pulses.

## Timing
- Reset values: `data`=0, `valid`=0, `parity_err`=0, `frame_err`=0, `busy`=0. Internal state returns to IDLE and the synchronizer is preset to 1.
- Reset asserted mid-frame aborts the frame in the next cycle, with no `valid`. After reset, a frame is recognized only after `rx_s` has been seen high.
- Synchronizer latency: 2 cycles from `rx` to `rx_s`.
- `busy` rises in the cycle after the falling edge on `rx_s` and falls in the cycle the FSM enters IDLE.
- Counter width is $clog2(CLKS_PER_BIT). The counter reloads and never wraps mid-bit.
- `valid` latency: `valid` asserts 1 cycle after the mid-stop sample. That is (DATA_BITS+2)·CLKS_PER_BIT + CLKS_PER_BIT/2 + 3 cycles after the `rx` falling edge. This is 171 cycles for the defaults.
- Back-to-back frames: a falling edge in the cycle IDLE is entered after STOP is accepted. No dead cycles are required beyond the remaining half of the stop bit.

## Structure
- Shared package `uart_pkg` holds:
  - `rx_state_t` enum (IDLE, START, DATA, PARITY, STOP, BREAK);
  - constant `UART_IDLE_LEVEL = 1'b1`;
  - function `parity_of(vec, odd)`, reused by the transmitter.
- Sub-module `sync_2ff` is the two-flop synchronizer, with a reset value parameter. It is natural to split out because the transmitter's flow-control input needs the same synchronizer.
- Everything else lives in one FSM plus datapath module.

## Test plan
All cases use defaults unless stated (DATA_BITS=8, CLKS_PER_BIT=16, even parity).
- Frame 0xA5 with parity bit 0 and stop 1 -> a single `valid` pulse, `data`=0xA5, `parity_err`=0, `frame_err`=0, `busy` low afterwards.
- Frame 0x07 with parity bit 0 (correct is 1) -> `valid`, `data`=0x07, `parity_err`=1, `frame_err`=0.
- `rx` low for 4 cycles, then high -> no `valid`, and `busy` returns to 0 within 12 cycles.
- Frame 0x3C with stop bit 0, line held low 100 cycles, then high, then frame 0x81 -> first `valid` with `frame_err`=1; second `valid` with `data`=0x81 and no errors.
- `rst` pulsed during DATA bit 3 of 0x55 -> all outputs 0 the next cycle and no `valid` for that frame. A following 0x55 frame is received correctly.
- PARITY_ODD=1, frame 0x00 with parity bit 1, immediately followed by 0xFF with parity bit 1 -> two `valid` pulses, both with `parity_err`=0.
